// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the handshaked data-memory responder:
// FSM encoding, access legality check and little-endian byte-lane packing.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Lane k of a word is bits [8k+7:8k], matching the original data memory.
  typedef logic [3:0][7:0] byte4_t;

  // The limit is compared in 32 bits before any indexing, so a + 3 never wraps.
  function automatic logic access_error(
    input logic        rd,
    input logic        wr,
    input logic [31:0] addr,
    input logic [31:0] depth
  );
    return (rd && wr) || (addr[1:0] != 2'b00) || (addr > (depth - 32'd4));
  endfunction

  function automatic byte4_t unpack_word(input logic [31:0] word);
    byte4_t b;
    for (int k = 0; k < 4; k++) begin
      b[k] = word[8*k +: 8];
    end
    return b;
  endfunction

  function automatic logic [31:0] pack_word(input byte4_t b);
    logic [31:0] word;
    for (int k = 0; k < 4; k++) begin
      word[8*k +: 8] = b[k];
    end
    return word;
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage with one 4-byte write port and one 4-byte combinational
// read port; contents are deliberately left uninitialised by reset.
module mem_byte_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  byte4_t        i_wbytes,
  input  logic [AW-1:0] i_raddr,
  output byte4_t        o_rbytes
);

  logic [7:0] r_mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < 4; k++) begin
        r_mem[i_waddr + AW'(k)] <= i_wbytes[k];
      end
    end
  end

  always_comb begin
    o_rbytes = '0;
    for (int k = 0; k < 4; k++) begin
      o_rbytes[k] = r_mem[i_raddr + AW'(k)];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Registered load/store slave: captures a request, inserts WAIT_CYCLES wait
// states, then commits the access and pulses mem_ready (with mem_error if illegal).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr_in,
  input  logic [31:0] in_data,
  output logic [31:0] out_data,
  output logic        mem_ready,
  output logic        mem_error,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic              r_rd;
  logic              r_wr;
  logic [31:0]       r_out_data;
  logic              r_ready;
  logic              r_error;
  logic              r_busy;

  logic              w_accept;
  logic              w_commit;
  logic [31:0]       w_op_addr;
  logic [31:0]       w_op_wdata;
  logic              w_op_rd;
  logic              w_op_wr;
  logic              w_op_err;
  logic              w_we;
  logic              w_rd_ok;
  byte4_t            w_rbytes;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_enable && (memread || memwrite)) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next_state = ST_RESP;
            w_commit     = 1'b1;
          end else begin
            w_next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == LAST_CNT) begin
          w_next_state = ST_RESP;
          w_commit     = 1'b1;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accepting edge, so the
  // live inputs are used instead of the not-yet-loaded capture registers.
  always_comb begin
    w_op_addr  = r_addr;
    w_op_wdata = r_wdata;
    w_op_rd    = r_rd;
    w_op_wr    = r_wr;
    if (r_state == ST_IDLE) begin
      w_op_addr  = addr_in;
      w_op_wdata = in_data;
      w_op_rd    = memread;
      w_op_wr    = memwrite;
    end
    w_op_err = access_error(w_op_rd, w_op_wr, w_op_addr, 32'(DEPTH_BYTES));
    w_we     = w_commit && w_op_wr && !w_op_err;
    w_rd_ok  = w_commit && w_op_rd && !w_op_err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == ST_WAIT) && !w_commit) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= addr_in;
      r_wdata <= in_data;
      r_rd    <= memread;
      r_wr    <= memwrite;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_data <= '0;
      r_ready    <= 1'b0;
      r_error    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ready <= w_commit;
      r_error <= w_commit && w_op_err;
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (r_state == ST_RESP) begin
        r_busy <= 1'b0;
      end
      if (w_rd_ok) begin
        r_out_data <= pack_word(w_rbytes);
      end
    end
  end

  mem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .AW          (AW)
  ) u_mem (
    .clk      (clk),
    .i_we     (w_we),
    .i_waddr  (w_op_addr[AW-1:0]),
    .i_wbytes (unpack_word(w_op_wdata)),
    .i_raddr  (w_op_addr[AW-1:0]),
    .o_rbytes (w_rbytes)
  );

  assign out_data  = r_out_data;
  assign mem_ready = r_ready;
  assign mem_error = r_error;
  assign busy      = r_busy;

endmodule
